// File: rtl/ahbl_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_pkg
// Shared definitions for the AHB-Lite single-transfer master controller:
//   - HTRANS encodings used by the master (IDLE / NONSEQ)
//   - HSIZE codes (byte / half / word / dword)
//   - per-stage control record shared by the address (A) and data (D) stages
//   - helper that returns the low-address alignment mask for a size code
// ---------------------------------------------------------------------------
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Control part of a pipeline stage. The address and write-data fields
    // depend on the AW/DW parameters, so the full stage record is composed
    // from this type inside the controller.
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] size;
    } stage_ctl_t;

    // Mask applied to addr[2:0] so the address is aligned down to the size.
    function automatic logic [2:0] size_low_mask(input logic [2:0] size);
        logic [2:0] mask;
        case (size)
            HSIZE_BYTE: mask = 3'b111;
            HSIZE_HALF: mask = 3'b110;
            HSIZE_WORD: mask = 3'b100;
            default:    mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahbl_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahbl_master_ctrl_if
// Bundles the command/response handshake and the AHB-Lite bus signals of
// the master controller.
//   master : controller view (drives cmd_ready, rsp_*, HADDR/HTRANS/HSIZE/
//            HWRITE/HWDATA; samples cmd_*, HREADY/HRDATA/HRESP)
//   slave  : environment view (the opposite directions)
// ---------------------------------------------------------------------------
interface ahbl_master_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    // command side
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;

    // response side
    logic          rsp_valid;
    logic          rsp_write;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    // AHB-Lite
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic [DW-1:0] HRDATA;
    logic          HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata,
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA, HRESP
    );

endinterface

// File: rtl/ahbl_lane.sv
// ---------------------------------------------------------------------------
// ahbl_lane
// Combinational byte-lane steering for a DW-bit AHB data bus.
//   EXTRACT = 0 : replicate the low (1<<size) bytes of din across all lanes
//   EXTRACT = 1 : shift din right by offset bytes and keep only the low
//                 (1<<size) bytes (little-endian read extraction)
// Ports: size (HSIZE code), offset (address low bits), din, dout.
// Size codes above the bus width are treated as full bus width.
// ---------------------------------------------------------------------------
module ahbl_lane
    import ahbl_pkg::*;
#(
    parameter int DW      = 32,
    parameter bit EXTRACT = 1'b0
) (
    input  logic [2:0]                size,
    input  logic [$clog2(DW/8)-1:0]   offset,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout
);

    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);

    logic [3:0]    nbytes_s;
    logic [OW-1:0] lane_mask_s;
    logic [DW-1:0] shifted_s;

    // Number of active bytes for the size code, clamped to the bus width.
    always_comb begin
        nbytes_s = 4'(NB);
        case (size)
            HSIZE_BYTE: nbytes_s = 4'd1;
            HSIZE_HALF: nbytes_s = 4'd2;
            HSIZE_WORD: nbytes_s = 4'd4;
            default:    nbytes_s = 4'(NB);
        endcase
    end

    assign lane_mask_s = OW'(nbytes_s - 4'd1);
    assign shifted_s   = din >> {offset, 3'b000};

    // Lane steering: each output byte picks its source byte.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NB; i++) begin
            if (EXTRACT) begin
                if (4'(i) < nbytes_s) begin
                    dout[i*8 +: 8] = shifted_s[i*8 +: 8];
                end else begin
                    dout[i*8 +: 8] = 8'h00;
                end
            end else begin
                // byte i repeats source byte (i mod nbytes)
                dout[i*8 +: 8] = din[{(OW'(i) & lane_mask_s), 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/ahbl_master_ctrl.sv
// ---------------------------------------------------------------------------
// ahbl_master_ctrl
// AHB-Lite master issuing SINGLE transfers from a valid/ready command port,
// with a two-stage pipeline: A (address phase) and D (data phase).
// Ports:
//   HCLK    : clock, all state changes on the rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : ahbl_master_ctrl_if.master (cmd_*, rsp_*, AHB-Lite signals)
// Responses come back in command order, one per accepted command. A
// two-cycle ERROR response forces IDLE in its second cycle and the command
// waiting in A is re-issued once the error completes.
// ---------------------------------------------------------------------------
module ahbl_master_ctrl
    import ahbl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahbl_master_ctrl_if.master bus
);

    localparam int OW = $clog2(DW / 8);

    typedef struct packed {
        stage_ctl_t    ctl;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } stage_t;

    stage_t        a_r, d_r;
    stage_t        a_next_s, d_next_s;
    logic          err_hold_r, err_next_s;
    logic [1:0]    htrans_r;
    logic          rsp_valid_r, rsp_write_r, rsp_err_r;
    logic [DW-1:0] rsp_rdata_r;

    logic          cmd_ready_s, accept_s, issue_s, d_done_s;
    logic [AW-1:0] cmd_addr_al_s;
    logic [DW-1:0] hwdata_s, rdata_lane_s;

    // While err_hold is set the A command is frozen, so no new command fits.
    assign cmd_ready_s   = !a_r.ctl.valid | (bus.HREADY & !err_hold_r);
    assign accept_s      = bus.cmd_valid & cmd_ready_s;
    assign issue_s       = bus.HREADY & a_r.ctl.valid & !err_hold_r;
    assign d_done_s      = bus.HREADY & d_r.ctl.valid;
    assign cmd_addr_al_s = {bus.cmd_addr[AW-1:3],
                            bus.cmd_addr[2:0] & size_low_mask(bus.cmd_size)};

    // Next-state of both pipeline stages and the error-hold flag.
    always_comb begin
        a_next_s   = a_r;
        d_next_s   = d_r;
        err_next_s = err_hold_r;

        if (accept_s) begin
            a_next_s.ctl.valid = 1'b1;
            a_next_s.ctl.write = bus.cmd_write;
            a_next_s.ctl.size  = bus.cmd_size;
            a_next_s.addr      = cmd_addr_al_s;
            a_next_s.wdata     = bus.cmd_wdata;
        end else if (issue_s) begin
            a_next_s.ctl.valid = 1'b0;
        end else begin
            a_next_s = a_r;
        end

        if (issue_s) begin
            d_next_s = a_r;
        end else if (d_done_s) begin
            d_next_s.ctl.valid = 1'b0;
        end else begin
            d_next_s = d_r;
        end

        // err_hold marks the second cycle of a two-cycle ERROR response.
        if (err_hold_r) begin
            err_next_s = !bus.HREADY;
        end else begin
            err_next_s = d_r.ctl.valid & bus.HRESP & !bus.HREADY;
        end
    end

    // Pipeline, error-hold and registered bus/response outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_r         <= '0;
            d_r         <= '0;
            err_hold_r  <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            a_r         <= a_next_s;
            d_r         <= d_next_s;
            err_hold_r  <= err_next_s;
            htrans_r    <= (a_next_s.ctl.valid & !err_next_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
            rsp_valid_r <= d_done_s;
            rsp_write_r <= d_done_s & d_r.ctl.write;
            rsp_err_r   <= d_done_s & bus.HRESP;
            rsp_rdata_r <= (d_done_s & !d_r.ctl.write & !bus.HRESP) ? rdata_lane_s : '0;
        end
    end

    ahbl_lane #(.DW(DW), .EXTRACT(1'b0)) u_wlane (
        .size   (d_r.ctl.size),
        .offset (d_r.addr[OW-1:0]),
        .din    (d_r.wdata),
        .dout   (hwdata_s)
    );

    ahbl_lane #(.DW(DW), .EXTRACT(1'b1)) u_rlane (
        .size   (d_r.ctl.size),
        .offset (d_r.addr[OW-1:0]),
        .din    (bus.HRDATA),
        .dout   (rdata_lane_s)
    );

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.HADDR     = a_r.addr;
    assign bus.HSIZE     = a_r.ctl.size;
    assign bus.HWRITE    = a_r.ctl.write;
    assign bus.HTRANS    = htrans_r;
    assign bus.HWDATA    = hwdata_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_write = rsp_write_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: doc/ahbl_master_ctrl.md
AHBL_MASTER_CTRL -- requirements
Module: ahbl_master_ctrl

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; legal values 32 or 64.
REQ-003 HCLK  in  1  single clock; all state changes on rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when valid&ready at a rising edge.
REQ-007 cmd_addr  in  AW  byte address.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_size  in  3  AHB size code (0=byte, 1=half, 2=word, 3=dword only when DW=64).
REQ-010 cmd_wdata  in  DW  write data, right-justified.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 rsp_write  out  1  completed transfer was a write.
REQ-013 rsp_err  out  1  completed transfer received HRESP=1.
REQ-014 rsp_rdata  out  DW  read data, right-justified and zero-extended; 0 for writes.
REQ-015 HADDR/HTRANS/HSIZE/HWRITE  out  AW/2/3/1  AHB-Lite address-phase signals.
REQ-016 HWDATA  out  DW  AHB-Lite write data.
REQ-017 HREADY/HRDATA/HRESP  in  1/DW/1  AHB-Lite slave response signals.

Function
REQ-018 Two-stage pipeline: A (address phase) register and D (data phase) register, each holding valid, write, size, addr, and wdata.
REQ-019 cmd_ready = !A.valid | (HREADY & !err_hold).
REQ-020 Accepted command is loaded into A; cmd_addr is aligned down to cmd_size; a command accepted at edge N drives HTRANS=NONSEQ (2'b10) in cycle N+1.
REQ-021 HTRANS = NONSEQ when A.valid & !err_hold, else IDLE (2'b00); HBURST is not provided and all transfers are SINGLE.
REQ-022 HADDR/HSIZE/HWRITE are driven from A and held stable while HREADY=0.
REQ-023 At an edge with HREADY=1 and HTRANS=NONSEQ: A moves to D, and A loads a new command or clears. Back-to-back commands give zero IDLE cycles.
REQ-024 At an edge with HREADY=1 and D.valid: D completes and clears unless refilled.
REQ-025 Completion of D at edge N raises rsp_valid in cycle N+1, with rsp_rdata captured from HRDATA at edge N.
REQ-026 HWDATA = D.wdata replicated across all lanes of size D.size.
REQ-027 rsp_rdata = HRDATA lanes selected by D.addr low bits (little-endian), shifted to bit 0.
REQ-028 Error, first cycle (D.valid & HRESP=1 & HREADY=0): set err_hold at the next edge. In the second cycle, HTRANS is forced to IDLE, A is retained, and A is not transferred.
REQ-029 err_hold clears at the edge where HREADY=1. The retained A command re-issues as NONSEQ in the following cycle.
REQ-030 The errored transfer completes with rsp_err=1 and rsp_rdata=0. Later commands continue normally and keep their order.
REQ-031 HREADY=0 wait states of any length stall both stages; no command is lost or duplicated.
REQ-032 Responses are delivered in command order, exactly one per accepted command.

Reset
REQ-033 On HRESETn=0: A.valid, D.valid, err_hold, rsp_valid, rsp_err, rsp_write=0; HTRANS=IDLE; HADDR, HSIZE, HWRITE, HWDATA, rsp_rdata=0; cmd_ready=1 after release.
REQ-034 Reset mid-transfer discards all in-flight commands, and no response is produced for them.

Structure
REQ-035 Shared package ahbl_pkg holds the HTRANS_IDLE/NONSEQ constants, the HSIZE_BYTE/HALF/WORD/DWORD codes, and the A/D stage struct typedef.
REQ-036 One combinational sub-module, ahbl_lane (replicate write lanes and extract read lanes by size/offset), is instantiated twice.

Verification
REQ-037 Single write: addr 0x0000_0004, data 0x1234_5678, size 2, HREADY=1 -> NONSEQ one cycle, HWDATA=0x12345678 the next cycle, rsp_valid with rsp_write=1, rsp_err=0.
REQ-038 Back-to-back writes to 0x00, 0x20000000, 0x40000000, 0x80000000, then a read of 0x00 -> five consecutive NONSEQ cycles, five in-order responses; the read returns the slave's HRDATA.
REQ-039 Byte read at 0x0000_0003 with HRDATA=0xAABBCCDD -> rsp_rdata=0x000000AA. Halfword write 0xBEEF at 0x2 -> HWDATA=0xBEEFBEEF.
REQ-040 Three HREADY=0 wait states on the data phase of a read while a write is pending -> HADDR and HWDATA stable, cmd_ready=0, both responses arrive after HREADY rises.
REQ-041 Two-cycle HRESP error on the first of two pipelined reads -> IDLE in the second error cycle, the second read re-issued, responses err=1 then err=0.
REQ-042 HRESETn asserted during a wait state -> HTRANS=IDLE immediately, no rsp_valid, and a clean transfer afterwards.
